// File: rtl/muldiv_pkg.sv
// Shared types and decode helpers for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } mdfunc_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } md_state_t;

  function automatic logic MDFUNC_IS_DIV(input mdfunc_t f);
    return f inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU};
  endfunction

  function automatic logic MDFUNC_IS_REM(input mdfunc_t f);
    return f inside {MD_REM, MD_REMU};
  endfunction

  function automatic logic MDFUNC_IS_SIGNED_A(input mdfunc_t f);
    return f inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
  endfunction

  function automatic logic MDFUNC_IS_SIGNED_B(input mdfunc_t f);
    return f inside {MD_MULH, MD_DIV, MD_REM};
  endfunction

endpackage

// File: rtl/muldiv_divstep.sv
// One radix-2 restoring division step: shift in the next dividend bit, subtract if it fits.
module muldiv_divstep
  import muldiv_pkg::*;
#(
  parameter int unsigned DWIDTH = 32
) (
  input  logic [DWIDTH-1:0] rem_i,
  input  logic              bit_i,
  input  logic [DWIDTH-1:0] divisor_i,
  output logic [DWIDTH-1:0] rem_c,
  output logic              q_c
);

  logic [DWIDTH:0] shifted;
  logic [DWIDTH:0] diff;

  always_comb begin
    shifted = {rem_i, bit_i};
    diff    = shifted - {1'b0, divisor_i};
    q_c     = (shifted >= {1'b0, divisor_i});
    rem_c   = q_c ? diff[DWIDTH-1:0] : shifted[DWIDTH-1:0];
  end

endmodule

// File: rtl/muldiv_iter.sv
// Multi-cycle RV32M multiply/divide: IDLE -> CALC -> FIX -> IDLE, with single-edge special cases.
module muldiv_iter
  import muldiv_pkg::*;
#(
  parameter int unsigned DWIDTH   = 32,
  parameter bit          FAST_MUL = 1'b1
) (
  input  logic              clock,
  input  logic              nReset,
  input  logic              start,
  input  logic              kill,
  input  logic [2:0]        MDFunc,
  input  logic [DWIDTH-1:0] A,
  input  logic [DWIDTH-1:0] B,
  output logic              ready,
  output logic              done,
  output logic [DWIDTH-1:0] MDOut
);

  localparam int unsigned CNT_W = $clog2(DWIDTH) + 1;
  localparam int unsigned PW    = 2 * DWIDTH;
  localparam logic [DWIDTH-1:0] MIN_NEG = {1'b1, {(DWIDTH-1){1'b0}}};

  md_state_t         state_q, state_d;
  mdfunc_t           fn_q, fn_d;
  logic              sign_a_q, sign_a_d, sign_b_q, sign_b_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DWIDTH-1:0] hi_q, hi_d, lo_q, lo_d, opb_q, opb_d;
  logic [DWIDTH-1:0] mdout_q, mdout_d;
  logic              ready_q, ready_d, done_q, done_d;

  mdfunc_t           fn_in;
  logic              sa_in, sb_in, div_in, b_zero, ovf;
  logic [DWIDTH-1:0] abs_a, abs_b, special_res;
  logic [PW-1:0]     prod_fast, prod, prod_fix;
  logic [DWIDTH:0]   mul_sum;
  logic [DWIDTH-1:0] step_rem;
  logic              step_q, neg_q;

  muldiv_divstep #(.DWIDTH(DWIDTH)) u_divstep (
    .rem_i     (hi_q),
    .bit_i     (lo_q[DWIDTH-1]),
    .divisor_i (opb_q),
    .rem_c     (step_rem),
    .q_c       (step_q)
  );

  // Operand decode and special-case detection for the accept edge.
  always_comb begin
    fn_in       = mdfunc_t'(MDFunc);
    sa_in       = MDFUNC_IS_SIGNED_A(fn_in) & A[DWIDTH-1];
    sb_in       = MDFUNC_IS_SIGNED_B(fn_in) & B[DWIDTH-1];
    abs_a       = sa_in ? -A : A;
    abs_b       = sb_in ? -B : B;
    div_in      = MDFUNC_IS_DIV(fn_in);
    b_zero      = (B == '0);
    ovf         = MDFUNC_IS_SIGNED_A(fn_in) && (A == MIN_NEG) && (B == '1);
    special_res = b_zero ? (MDFUNC_IS_REM(fn_in) ? A : '1)
                         : (MDFUNC_IS_REM(fn_in) ? '0 : A);
    prod_fast   = {{DWIDTH{1'b0}}, abs_a} * {{DWIDTH{1'b0}}, abs_b};
    mul_sum     = {1'b0, hi_q} + {1'b0, (lo_q[0] ? opb_q : '0)};
    neg_q       = sign_a_q ^ sign_b_q;
    prod        = {hi_q, lo_q};
    prod_fix    = neg_q ? -prod : prod;
  end

  always_comb begin
    state_d  = state_q;
    fn_d     = fn_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opb_d    = opb_q;
    mdout_d  = mdout_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !kill) begin
          fn_d     = fn_in;
          sign_a_d = sa_in;
          sign_b_d = sb_in;
          if (div_in && (b_zero || ovf)) begin
            mdout_d = special_res;
            done_d  = 1'b1;
          end else if (div_in) begin
            hi_d    = '0;
            lo_d    = abs_a;
            opb_d   = abs_b;
            cnt_d   = CNT_W'(DWIDTH);
            state_d = CALC;
          end else if (FAST_MUL) begin
            hi_d    = prod_fast[PW-1:DWIDTH];
            lo_d    = prod_fast[DWIDTH-1:0];
            state_d = FIX;
          end else begin
            hi_d    = '0;
            lo_d    = abs_b;
            opb_d   = abs_a;
            cnt_d   = CNT_W'(DWIDTH);
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (kill) begin
          state_d = IDLE;
        end else begin
          // Divide shifts quotient bits into lo; multiply shifts the multiplier out of lo.
          if (MDFUNC_IS_DIV(fn_q)) begin
            hi_d = step_rem;
            lo_d = {lo_q[DWIDTH-2:0], step_q};
          end else begin
            {hi_d, lo_d} = {mul_sum, lo_q[DWIDTH-1:1]};
          end
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = FIX;
        end
      end
      FIX: begin
        state_d = IDLE;
        if (!kill) begin
          done_d = 1'b1;
          if (MDFUNC_IS_REM(fn_q))      mdout_d = sign_a_q ? -hi_q : hi_q;
          else if (MDFUNC_IS_DIV(fn_q)) mdout_d = neg_q ? -lo_q : lo_q;
          else if (fn_q == MD_MUL)      mdout_d = prod_fix[DWIDTH-1:0];
          else                          mdout_d = prod_fix[PW-1:DWIDTH];
        end
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      state_q  <= IDLE;
      fn_q     <= MD_MUL;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      opb_q    <= '0;
      mdout_q  <= '0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      fn_q     <= fn_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opb_q    <= opb_d;
      mdout_q  <= mdout_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
    end
  end

  assign ready = ready_q;
  assign done  = done_q;
  assign MDOut = mdout_q;

endmodule

// File: tb/tb_muldiv_iter.sv
// Scoreboard bench for muldiv_iter: a fast-multiply and an iterative-multiply instance, 32-bit.
module tb_muldiv_iter;

  localparam int LAT_SPEC = 0;   // edges from accept edge to the edge that raises done
  localparam int LAT_FAST = 1;
  localparam int LAT_ITER = 33;

  logic        clock = 1'b0;
  logic        nReset = 1'b0;
  logic        start0 = 1'b0, start1 = 1'b0, kill = 1'b0;
  logic [2:0]  MDFunc = 3'd0;
  logic [31:0] A = '0, B = '0;
  logic        ready0, done0, ready1, done1;
  logic [31:0] MDOut0, MDOut1;

  typedef struct {
    logic [31:0] val;
    int          acc;
    int          lat;
    string       name;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  logic [31:0] last0 = '0;

  muldiv_iter #(.DWIDTH(32), .FAST_MUL(1'b1)) u_fast (
    .clock(clock), .nReset(nReset), .start(start0), .kill(kill), .MDFunc(MDFunc),
    .A(A), .B(B), .ready(ready0), .done(done0), .MDOut(MDOut0)
  );

  muldiv_iter #(.DWIDTH(32), .FAST_MUL(1'b0)) u_iter (
    .clock(clock), .nReset(nReset), .start(start1), .kill(kill), .MDFunc(MDFunc),
    .A(A), .B(B), .ready(ready1), .done(done1), .MDOut(MDOut1)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitors: pop one expectation per done pulse and check value and latency.
  always @(negedge clock) begin
    if (done0 === 1'b1) begin
      if (q0.size() == 0) begin
        n_checks++;
        $display("FAIL fast_unexpected_done: got MDOut %h expected no done", MDOut0);
      end else begin
        exp_t e;
        e = q0.pop_front();
        check(e.name, MDOut0, e.val);
        check({e.name, "_lat"}, 32'(cyc - e.acc), 32'(e.lat));
      end
    end
    if (done1 === 1'b1) begin
      if (q1.size() == 0) begin
        n_checks++;
        $display("FAIL iter_unexpected_done: got MDOut %h expected no done", MDOut1);
      end else begin
        exp_t e;
        e = q1.pop_front();
        check(e.name, MDOut1, e.val);
        check({e.name, "_lat"}, 32'(cyc - e.acc), 32'(e.lat));
      end
    end
  end

  task automatic issue(input bit d, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat, input string name, input bit track);
    int   g;
    exp_t e;
    g = 0;
    @(negedge clock);
    while (!(d ? ready1 : ready0)) begin
      g++;
      if (g > 200) begin
        n_checks++;
        $display("FAIL %s_ready_timeout: got ready low expected high within 200 cycles", name);
        return;
      end
      @(negedge clock);
    end
    MDFunc = f; A = a; B = b;
    if (d) start1 = 1'b1; else start0 = 1'b1;
    if (track) begin
      e.val = exp; e.acc = cyc + 1; e.lat = lat; e.name = name;
      if (d) q1.push_back(e);
      else begin q0.push_back(e); last0 = exp; end
    end
    @(negedge clock);
    start0 = 1'b0; start1 = 1'b0;
    A = $urandom; B = $urandom; MDFunc = 3'($urandom_range(7));
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((q0.size() != 0 || q1.size() != 0) && g < 500) begin
      @(negedge clock);
      g++;
    end
    if (g >= 500) begin
      n_checks++;
      $display("FAIL drain: got %0d/%0d results pending expected 0/0", q0.size(), q1.size());
    end
  endtask

  initial begin
    int acc1;
    repeat (3) @(negedge clock);
    check("rst_ready", {31'd0, ready0}, 32'd1);
    check("rst_done", {31'd0, done0}, 32'd0);
    check("rst_mdout", MDOut0, 32'd0);
    nReset = 1'b1;

    // Divide with sign fix-up, and the single-edge special cases.
    issue(0, 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, LAT_ITER, "div_m7_2", 1);
    issue(0, 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, LAT_ITER, "rem_m7_2", 1);
    issue(0, 3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, LAT_SPEC, "divu_by0", 1);
    issue(0, 3'b111, 32'd5, 32'd0, 32'd5, LAT_SPEC, "remu_by0", 1);
    issue(0, 3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, LAT_SPEC, "div_by0", 1);
    issue(0, 3'b110, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, LAT_SPEC, "rem_m5_by0", 1);
    issue(0, 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LAT_SPEC, "div_ovf", 1);
    issue(0, 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, LAT_SPEC, "rem_ovf", 1);
    issue(0, 3'b100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, LAT_ITER, "div_100_m7", 1);
    issue(0, 3'b110, 32'd100, 32'hFFFF_FFF9, 32'd2, LAT_ITER, "rem_100_m7", 1);
    issue(0, 3'b110, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, LAT_ITER, "rem_m100_7", 1);
    issue(0, 3'b101, 32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF, LAT_ITER, "divu_max_2", 1);

    // Multiply variants on both instances.
    issue(0, 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, LAT_FAST, "f_mulh_min", 1);
    issue(0, 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, LAT_FAST, "f_mulhsu", 1);
    issue(0, 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, LAT_FAST, "f_mulhu", 1);
    issue(0, 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, LAT_FAST, "f_mul_m1", 1);
    issue(0, 3'b000, 32'h1234_5678, 32'h10, 32'h2345_6780, LAT_FAST, "f_mul_x16", 1);
    issue(0, 3'b001, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, LAT_FAST, "f_mulh_m3_5", 1);
    issue(0, 3'b000, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, LAT_FAST, "f_mul_m3_5", 1);
    issue(1, 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, LAT_ITER, "i_mulh_min", 1);
    issue(1, 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, LAT_ITER, "i_mulhsu", 1);
    issue(1, 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, LAT_ITER, "i_mulhu", 1);
    issue(1, 3'b000, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, LAT_ITER, "i_mul_m3_5", 1);
    issue(1, 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, LAT_ITER, "i_div_m7_2", 1);
    drain();

    // Back-to-back: start held; the REMU is taken on the DIVU's done cycle.
    @(negedge clock);
    MDFunc = 3'b101; A = 32'd100; B = 32'd7; start0 = 1'b1;
    acc1 = cyc + 1;
    q0.push_back('{32'd14, acc1, LAT_ITER, "b2b_divu"});
    q0.push_back('{32'd2, acc1 + LAT_ITER + 1, LAT_ITER, "b2b_remu"});
    last0 = 32'd2;
    @(negedge clock);
    MDFunc = 3'b111;
    while (cyc < acc1 + LAT_ITER + 1) @(negedge clock);
    start0 = 1'b0;
    drain();

    // Kill mid-divide: no done, unit idle next cycle, result register untouched.
    issue(0, 3'b100, 32'd1000, 32'd3, 32'd0, 0, "kill_div", 0);
    repeat (9) @(negedge clock);
    kill = 1'b1;
    @(negedge clock);
    kill = 1'b0;
    check("kill_ready", {31'd0, ready0}, 32'd1);
    check("kill_mdout", MDOut0, last0);
    repeat (40) @(negedge clock);

    // start with kill on a special-case op and on a normal op: neither accepted.
    MDFunc = 3'b101; A = 32'd5; B = 32'd0; start0 = 1'b1; kill = 1'b1;
    @(negedge clock);
    start0 = 1'b0; kill = 1'b0;
    check("killstart_spec_done", {31'd0, done0}, 32'd0);
    check("killstart_spec_mdout", MDOut0, last0);
    MDFunc = 3'b100; A = 32'd50; B = 32'd5; start0 = 1'b1; kill = 1'b1;
    @(negedge clock);
    start0 = 1'b0; kill = 1'b0;
    check("killstart_div_ready", {31'd0, ready0}, 32'd1);
    repeat (40) @(negedge clock);

    // Async reset mid-CALC, then a fresh op.
    issue(0, 3'b100, 32'd1000, 32'd3, 32'd0, 0, "rst_div", 0);
    repeat (4) @(negedge clock);
    #2 nReset = 1'b0;
    #1;
    check("midrst_ready", {31'd0, ready0}, 32'd1);
    check("midrst_done", {31'd0, done0}, 32'd0);
    check("midrst_mdout", MDOut0, 32'd0);
    @(negedge clock);
    nReset = 1'b1;
    issue(0, 3'b101, 32'd100, 32'd7, 32'd14, LAT_ITER, "post_rst_divu", 1);
    drain();
    repeat (3) @(negedge clock);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
